sm_rule_arbiter: RTL and testbench

SM_RULE_ARBITER -- requirements
Module: sm_rule_arbiter

---
 rtl/sm_rule_arbiter_pkg.sv | 20 ++
 rtl/sm_rule_arbiter_rr_pick.sv | 29 ++
 rtl/sm_rule_arbiter.sv | 149 ++++++++++++++
 tb/tb_sm_rule_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sm_rule_arbiter_pkg.sv
// Shared types for the rule-stream arbiter.
// Holds the FSM state enum, the requester ceiling and a wrap helper.
package sm_rule_arbiter_pkg;

  localparam int MAX_NUM_IN = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  function automatic int wrap_add(
    input int a,
    input int b,
    input int n
  );
    return (a + b) % n;
  endfunction

endpackage

// File: rtl/sm_rule_arbiter_rr_pick.sv
// Round-robin picker: first set request at or above ptr, modulo N.
// Returns a one-hot grant, its index and an any-request flag.
module rr_pick
  import sm_rule_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any && req[wrap_add(int'(ptr), k, N)]) begin
        any = 1'b1;
        idx = IW'(wrap_add(int'(ptr), k, N));
      end
    end
    if (any) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/sm_rule_arbiter.sv
// Packet-atomic round-robin merge of string-matcher rule streams.
// Optional per-requester eop counters under SM_ARB_STATS_EN.
module sm_rule_arbiter
  import sm_rule_arbiter_pkg::*;
#(
  parameter int NUM_IN  = 4,
  parameter int DATA_W  = 512,
  parameter int EMPTY_W = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_IN-1:0]           in_sop,
  input  logic [NUM_IN-1:0]           in_eop,
  input  logic [NUM_IN*DATA_W-1:0]    in_data,
  input  logic [NUM_IN*EMPTY_W-1:0]   in_empty,
  input  logic [NUM_IN-1:0]           in_valid,
  output logic [NUM_IN-1:0]           in_ready,
  output logic                        out_sop,
  output logic                        out_eop,
  output logic [DATA_W-1:0]           out_data,
  output logic [EMPTY_W-1:0]          out_empty,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(NUM_IN)-1:0]   out_channel,
  output logic                        err_no_sop,
  output logic [NUM_IN*32-1:0]        stats_pkt
);

  localparam int IW = $clog2(NUM_IN);

  if (NUM_IN < 2 || NUM_IN > MAX_NUM_IN) begin : g_bad_num_in
    $error("sm_rule_arbiter: NUM_IN out of range");
  end

  arb_state_t      state, state_nx;
  logic [IW-1:0]   rr_ptr, rr_ptr_nx;
  logic [IW-1:0]   owner, owner_nx;
  logic [IW-1:0]   sel;
  logic            load, accept, viol;
  logic [NUM_IN-1:0] req, lock_mask;
  logic [NUM_IN-1:0] pick_gnt;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;

  assign load = !out_valid || out_ready;
  assign req  = in_valid & in_sop;

  rr_pick #(
    .N  (NUM_IN),
    .IW (IW)
  ) u_pick (
    .req (req),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    state_nx  = state;
    rr_ptr_nx = rr_ptr;
    owner_nx  = owner;
    sel       = pick_idx;
    accept    = 1'b0;
    in_ready  = '0;
    lock_mask = '0;
    unique case (state)
      IDLE: begin
        if (pick_any && load) begin
          accept   = 1'b1;
          in_ready = pick_gnt;
        end
      end
      LOCKED: begin
        sel              = owner;
        lock_mask[owner] = 1'b1;
        in_ready[owner]  = load;
        accept           = load && in_valid[owner];
      end
      default: ;
    endcase
    if (rst) begin
      accept   = 1'b0;
      in_ready = '0;
    end
    if (accept) begin
      if (in_eop[sel]) begin
        state_nx  = IDLE;
        rr_ptr_nx = IW'(wrap_add(int'(sel), 1, NUM_IN));
      end else begin
        state_nx = LOCKED;
        owner_nx = sel;
      end
    end
  end

  // mid-packet flits are only legal from the requester holding the lock
  assign viol = |(in_valid & ~in_sop & ~lock_mask);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      owner       <= '0;
      out_valid   <= 1'b0;
      out_sop     <= 1'b0;
      out_eop     <= 1'b0;
      out_data    <= '0;
      out_empty   <= '0;
      out_channel <= '0;
      err_no_sop  <= 1'b0;
    end else begin
      state  <= state_nx;
      rr_ptr <= rr_ptr_nx;
      owner  <= owner_nx;
      if (viol) err_no_sop <= 1'b1;
      if (load) begin
        out_valid <= accept;
        if (accept) begin
          out_sop     <= in_sop[sel];
          out_eop     <= in_eop[sel];
          out_data    <= in_data[int'(sel)*DATA_W +: DATA_W];
          out_empty   <= in_empty[int'(sel)*EMPTY_W +: EMPTY_W];
          out_channel <= sel;
        end
      end
    end
  end

`ifdef SM_ARB_STATS_EN
  logic [31:0] cnt_q [NUM_IN];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_IN; i++) cnt_q[i] <= '0;
    end else if (accept && in_eop[sel]) begin
      cnt_q[sel] <= cnt_q[sel] + 32'd1;
    end
  end

  always_comb begin
    stats_pkt = '0;
    for (int i = 0; i < NUM_IN; i++) stats_pkt[i*32 +: 32] = cnt_q[i];
  end
`else
  assign stats_pkt = '0;
`endif

endmodule

// File: tb/tb_sm_rule_arbiter.sv
// Self-checking bench for sm_rule_arbiter: vector table,
// directed multi-cycle sequences and a randomized model run.
module tb_sm_rule_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int EW = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    in_sop, in_eop, in_valid, in_ready;
  logic [N*DW-1:0] in_data;
  logic [N*EW-1:0] in_empty;
  logic            out_sop, out_eop, out_valid, out_ready;
  logic [DW-1:0]   out_data;
  logic [EW-1:0]   out_empty;
  logic [1:0]      out_channel;
  logic            err_no_sop;
  logic [N*32-1:0] stats_pkt;

  always #5 clk = ~clk;

  sm_rule_arbiter #(
    .NUM_IN  (N),
    .DATA_W  (DW),
    .EMPTY_W (EW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_sop      (in_sop),
    .in_eop      (in_eop),
    .in_data     (in_data),
    .in_empty    (in_empty),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_sop     (out_sop),
    .out_eop     (out_eop),
    .out_data    (out_data),
    .out_empty   (out_empty),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_channel (out_channel),
    .err_no_sop  (err_no_sop),
    .stats_pkt   (stats_pkt)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0] v;
    logic [3:0] s;
    logic [3:0] rdy;
    logic       err;
    logic [1:0] ch;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic idle_in();
    in_valid = '0;
    in_sop   = '0;
    in_eop   = '0;
    in_data  = '0;
    in_empty = '0;
  endtask

  task automatic set_flit(input int i, input logic v, input logic s,
                          input logic e, input logic [DW-1:0] d);
    in_valid[i]          = v;
    in_sop[i]            = s;
    in_eop[i]            = e;
    in_data[i*DW +: DW]  = d;
    in_empty[i*EW +: EW] = d[EW-1:0];
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_in();
    out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_out(input string nm, input logic v, input logic [1:0] ch,
                         input logic s, input logic e, input logic [DW-1:0] d);
    chk({nm, ".valid"}, out_valid, v);
    if (v) begin
      chk({nm, ".chan"}, out_channel, ch);
      chk({nm, ".sop"}, out_sop, s);
      chk({nm, ".eop"}, out_eop, e);
      chk({nm, ".data"}, out_data, d);
      chk({nm, ".empty"}, out_empty, d[EW-1:0]);
    end
  endtask

  // behavioural reference state for the random run
  int          pos[N], plen[N], seq[N], eopcnt[N];
  logic        m_lock, m_outv, m_acc, m_load;
  int          m_own, m_ptr, m_win;
  logic [N-1:0] m_rdy;
  logic [1:0]  e_ch;
  logic        e_sop, e_eop;
  logic [DW-1:0] e_data;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{v: 4'b0001, s: 4'b0001, rdy: 4'b0001, err: 1'b0, ch: 2'd0};
    tbl[1] = '{v: 4'b1010, s: 4'b1010, rdy: 4'b0010, err: 1'b0, ch: 2'd1};
    tbl[2] = '{v: 4'b1000, s: 4'b1000, rdy: 4'b1000, err: 1'b0, ch: 2'd3};
    tbl[3] = '{v: 4'b0110, s: 4'b0100, rdy: 4'b0100, err: 1'b1, ch: 2'd2};
    tbl[4] = '{v: 4'b0000, s: 4'b0000, rdy: 4'b0000, err: 1'b0, ch: 2'd0};
    tbl[5] = '{v: 4'b1111, s: 4'b0000, rdy: 4'b0000, err: 1'b1, ch: 2'd0};
    tbl[6] = '{v: 4'b1100, s: 4'b1100, rdy: 4'b0100, err: 1'b0, ch: 2'd2};

    rst = 1'b1;
    out_ready = 1'b1;
    idle_in();
    repeat (2) @(negedge clk);
    for (int i = 0; i < N; i++) set_flit(i, 1'b1, 1'b1, 1'b1, 32'h5000 + i);
    #1;
    chk("rst.in_ready", in_ready, 4'b0000);
    chk("rst.out_valid", out_valid, 1'b0);
    chk("rst.err", err_no_sop, 1'b0);
    chk("rst.chan", out_channel, 2'd0);
    chk("rst.sop", out_sop, 1'b0);
    chk("rst.eop", out_eop, 1'b0);
    chk("rst.data", out_data, 0);
    chk("rst.empty", out_empty, 0);
    chk("rst.stats_lo", stats_pkt[63:0], 0);
    chk("rst.stats_hi", stats_pkt[127:64], 0);
    in_sop = '0;
    @(negedge clk);
    chk("rst.err_hold", err_no_sop, 1'b0);

    for (int t = 0; t < 7; t++) begin
      do_reset();
      for (int i = 0; i < N; i++)
        set_flit(i, tbl[t].v[i], tbl[t].s[i], 1'b1, 32'hE000 + i);
      #1;
      chk($sformatf("tbl%0d.in_ready", t), in_ready, tbl[t].rdy);
      @(negedge clk);
      chk($sformatf("tbl%0d.err", t), err_no_sop, tbl[t].err);
      chk($sformatf("tbl%0d.out_valid", t), out_valid, |tbl[t].rdy);
      if (|tbl[t].rdy)
        chk($sformatf("tbl%0d.chan", t), out_channel, tbl[t].ch);
    end

    do_reset();
    for (int i = 0; i < N; i++) set_flit(i, 1'b1, 1'b1, 1'b1, 32'hA000 + i);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk_out($sformatf("rr%0d", k), 1'b1, 2'(k % 4), 1'b1, 1'b1,
              32'hA000 + (k % 4));
    end

    do_reset();
    set_flit(2, 1'b1, 1'b1, 1'b0, 32'hB201);
    #1 chk("lock.rdy0", in_ready, 4'b0100);
    @(negedge clk);
    chk_out("lock.f1", 1'b1, 2'd2, 1'b1, 1'b0, 32'hB201);
    set_flit(2, 1'b1, 1'b0, 1'b0, 32'hB202);
    set_flit(0, 1'b1, 1'b1, 1'b1, 32'hB001);
    #1 chk("lock.rdy1", in_ready, 4'b0100);
    @(negedge clk);
    chk_out("lock.f2", 1'b1, 2'd2, 1'b0, 1'b0, 32'hB202);
    set_flit(2, 1'b1, 1'b0, 1'b1, 32'hB203);
    #1 chk("lock.rdy2", in_ready, 4'b0100);
    @(negedge clk);
    chk_out("lock.f3", 1'b1, 2'd2, 1'b0, 1'b1, 32'hB203);
    set_flit(2, 1'b0, 1'b0, 1'b0, 32'h0);
    #1 chk("lock.rdy3", in_ready, 4'b0001);
    @(negedge clk);
    chk_out("lock.r0", 1'b1, 2'd0, 1'b1, 1'b1, 32'hB001);
    chk("lock.err", err_no_sop, 1'b0);

    do_reset();
    set_flit(1, 1'b1, 1'b1, 1'b0, 32'hC101);
    #1 chk("bp.rdy0", in_ready, 4'b0010);
    @(negedge clk);
    chk_out("bp.f1", 1'b1, 2'd1, 1'b1, 1'b0, 32'hC101);
    set_flit(1, 1'b1, 1'b0, 1'b0, 32'hC102);
    set_flit(0, 1'b1, 1'b1, 1'b1, 32'hC001);
    #1 chk("bp.rdy1", in_ready, 4'b0010);
    @(negedge clk);
    chk_out("bp.f2", 1'b1, 2'd1, 1'b0, 1'b0, 32'hC102);
    set_flit(1, 1'b1, 1'b0, 1'b1, 32'hC103);
    out_ready = 1'b0;
    #1 chk("bp.rdy2", in_ready, 4'b0000);
    @(negedge clk);
    chk_out("bp.hold1", 1'b1, 2'd1, 1'b0, 1'b0, 32'hC102);
    #1 chk("bp.rdy3", in_ready, 4'b0000);
    @(negedge clk);
    chk_out("bp.hold2", 1'b1, 2'd1, 1'b0, 1'b0, 32'hC102);
    out_ready = 1'b1;
    #1 chk("bp.rdy4", in_ready, 4'b0010);
    @(negedge clk);
    chk_out("bp.f3", 1'b1, 2'd1, 1'b0, 1'b1, 32'hC103);
    set_flit(1, 1'b1, 1'b1, 1'b1, 32'hC111);
    #1 chk("bp.rdy5", in_ready, 4'b0001);
    @(negedge clk);
    chk_out("bp.r0", 1'b1, 2'd0, 1'b1, 1'b1, 32'hC001);

    do_reset();
    set_flit(1, 1'b1, 1'b0, 1'b1, 32'hD100);
    #1 chk("perr.rdy", in_ready, 4'b0000);
    @(negedge clk);
    chk("perr.err", err_no_sop, 1'b1);
    chk("perr.out_valid", out_valid, 1'b0);
    idle_in();
    repeat (3) @(negedge clk);
    chk("perr.sticky", err_no_sop, 1'b1);
    do_reset();
    chk("perr.cleared", err_no_sop, 1'b0);

    set_flit(3, 1'b1, 1'b1, 1'b0, 32'hF301);
    @(negedge clk);
    chk_out("rmp.f1", 1'b1, 2'd3, 1'b1, 1'b0, 32'hF301);
    set_flit(3, 1'b1, 1'b0, 1'b0, 32'hF302);
    rst = 1'b1;
    #1 chk("rmp.rdy_rst", in_ready, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    chk("rmp.out_valid", out_valid, 1'b0);
    idle_in();
    set_flit(0, 1'b1, 1'b1, 1'b1, 32'hF001);
    #1 chk("rmp.rdy_new", in_ready, 4'b0001);
    @(negedge clk);
    chk_out("rmp.new", 1'b1, 2'd0, 1'b1, 1'b1, 32'hF001);
    chk("rmp.err", err_no_sop, 1'b0);

    do_reset();
    m_lock = 1'b0;
    m_outv = 1'b0;
    m_own  = 0;
    m_ptr  = 0;
    for (int i = 0; i < N; i++) begin
      pos[i]    = 0;
      plen[i]   = $urandom_range(1, 4);
      seq[i]    = 0;
      eopcnt[i] = 0;
    end
    for (int c = 0; c < 3000; c++) begin
      if (c > 0) chk_out("rnd", m_outv, e_ch, e_sop, e_eop, e_data);
      for (int i = 0; i < N; i++)
        set_flit(i, $urandom_range(0, 3) != 0, pos[i] == 0,
                 pos[i] == plen[i] - 1, DW'((i << 24) | seq[i]));
      out_ready = $urandom_range(0, 3) != 0;
      m_load = !m_outv || out_ready;
      m_win = -1;
      m_rdy = '0;
      if (m_lock) begin
        if (in_valid[m_own]) m_win = m_own;
        if (m_load) m_rdy[m_own] = 1'b1;
      end else begin
        for (int k = 0; k < N; k++)
          if (m_win < 0 && in_valid[(m_ptr + k) % N] && in_sop[(m_ptr + k) % N])
            m_win = (m_ptr + k) % N;
        if (m_load && m_win >= 0) m_rdy[m_win] = 1'b1;
      end
      m_acc = m_load && m_win >= 0;
      #1 chk("rnd.in_ready", in_ready, m_rdy);
      if (m_acc) begin
        m_outv = 1'b1;
        e_ch   = 2'(m_win);
        e_sop  = pos[m_win] == 0;
        e_eop  = pos[m_win] == plen[m_win] - 1;
        e_data = DW'((m_win << 24) | seq[m_win]);
        seq[m_win]++;
        if (e_eop) begin
          m_lock = 1'b0;
          m_ptr  = (m_win + 1) % N;
          eopcnt[m_win]++;
          pos[m_win]  = 0;
          plen[m_win] = $urandom_range(1, 4);
        end else begin
          m_lock = 1'b1;
          m_own  = m_win;
          pos[m_win]++;
        end
      end else if (m_load) begin
        m_outv = 1'b0;
      end
      @(negedge clk);
    end
    chk_out("rnd.last", m_outv, e_ch, e_sop, e_eop, e_data);
    chk("rnd.err", err_no_sop, 1'b0);
    for (int i = 0; i < N; i++) begin
`ifdef SM_ARB_STATS_EN
      chk($sformatf("stats%0d", i), stats_pkt[i*32 +: 32], 32'(eopcnt[i]));
`else
      chk($sformatf("stats%0d", i), stats_pkt[i*32 +: 32], 32'd0);
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
